// File: rtl/rv_exec_md.sv
// Execute stage: single-cycle ALU plus an iterative RV M-extension engine
// retiring STEP_BITS product/quotient bits per clock.
module rv_exec_md #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1,
  parameter int EN_MD     = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-3:0] i_pc,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_alu_op1_sel,
  input  logic            i_alu_op2_sel,
  input  logic [4:0]      i_alu_ctrl,
  input  logic            i_md_en,
  input  logic [2:0]      i_md_op,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_reg_write,
  output logic            o_busy
);

  localparam int K   = XLEN / STEP_BITS;
  localparam int CW  = $clog2(K);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_e;

  state_e          state_q, state_d;
  logic            valid_q, rw_q, neg_q, rneg_q, spec_q;
  logic [4:0]      rd_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q, b_q, m_q;
  logic [XLEN:0]   a_q;

  logic            cap, md_cap, last;
  logic [XLEN-1:0] rs1_v, rs2_v, op1, op2, alu_res;
  logic [SHW-1:0]  shamt;
  logic            s1, s2, n1, n2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign o_ready = (EN_MD == 0) || (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_busy  = (EN_MD != 0) && ((state_q == S_MUL) || (state_q == S_DIV));
  assign cap     = i_valid && o_ready && !i_flush;
  assign md_cap  = cap && (EN_MD != 0) && i_md_en;
  assign last    = (cnt_q == CW'(K - 1));

  assign rs1_v = (i_rs1 == 5'd0) ? '0 : i_rs1_val;
  assign rs2_v = (i_rs2 == 5'd0) ? '0 : i_rs2_val;
  assign op1   = i_alu_op1_sel ? {i_pc, 2'b00} : rs1_v;
  assign op2   = i_alu_op2_sel ? i_imm : rs2_v;
  assign shamt = op2[SHW-1:0];

  always_comb begin
    alu_res = op2;
    case (alu_e'(i_alu_ctrl))
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SLL:  alu_res = op1 << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SRL:  alu_res = op1 >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op1) >>> shamt);
      ALU_OR:   alu_res = op1 | op2;
      ALU_AND:  alu_res = op1 & op2;
      default:  alu_res = op2;
    endcase
  end

  // Operand signedness: divides are signed when funct3[0]=0; MULHSU keeps rs2 unsigned.
  assign s1       = i_md_op[2] ? ~i_md_op[0] : (i_md_op[1:0] != 2'b11);
  assign s2       = i_md_op[2] ? ~i_md_op[0] : ~i_md_op[1];
  assign n1       = s1 & rs1_v[XLEN-1];
  assign n2       = s2 & rs2_v[XLEN-1];
  assign mag1     = n1 ? -rs1_v : rs1_v;
  assign mag2     = n2 ? -rs2_v : rs2_v;
  assign div_zero = (rs2_v == '0);
  assign div_ovf  = ~i_md_op[0] && (rs1_v == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_v == '1);

  // Multiply step: a_q holds the running high half, b_q shifts the multiplier out / product low half in.
  logic [XLEN+STEP_BITS-1:0] partial, sum;
  logic [XLEN:0]             mul_a_nxt;
  logic [XLEN-1:0]           mul_b_nxt;
  logic [2*XLEN-1:0]         prod, prod_s;
  logic [XLEN-1:0]           mul_res;

  always_comb begin
    partial   = {{STEP_BITS{1'b0}}, m_q} * {{XLEN{1'b0}}, b_q[STEP_BITS-1:0]};
    sum       = {{STEP_BITS{1'b0}}, a_q[XLEN-1:0]} + partial;
    mul_a_nxt = {1'b0, sum[XLEN+STEP_BITS-1:STEP_BITS]};
    mul_b_nxt = {sum[STEP_BITS-1:0], b_q[XLEN-1:STEP_BITS]};
    prod      = {mul_a_nxt[XLEN-1:0], mul_b_nxt};
    prod_s    = neg_q ? -prod : prod;
    mul_res   = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // Restoring divide: a_q is the partial remainder, b_q the dividend shifting into the quotient.
  logic [XLEN:0]   r;
  logic [XLEN-1:0] q, div_res;

  always_comb begin
    r = a_q;
    q = b_q;
    for (int unsigned i = 0; i < STEP_BITS; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, m_q}) begin
        r    = r - {1'b0, m_q};
        q[0] = 1'b1;
      end
    end
    if (op_q[1]) div_res = rneg_q ? -r[XLEN-1:0] : r[XLEN-1:0];
    else         div_res = neg_q ? -q : q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (md_cap) state_d = i_md_op[2] ? S_DIV : S_MUL;
      end
      S_MUL:   if (last) state_d = S_DONE;
      S_DIV:   if (spec_q || last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (!i_flush) begin
        if (cap) begin
          rd_q <= i_rd;
          rw_q <= i_reg_write;
          if (md_cap) begin
            op_q   <= i_md_op;
            cnt_q  <= '0;
            a_q    <= '0;
            neg_q  <= n1 ^ n2;
            rneg_q <= n1;
            spec_q <= 1'b0;
            if (i_md_op[2]) begin
              m_q <= mag2;
              b_q <= mag1;
              // Special divides park their final answer in b_q and finish on the next edge.
              if (div_zero) begin
                spec_q <= 1'b1;
                b_q    <= i_md_op[1] ? rs1_v : '1;
              end else if (div_ovf) begin
                spec_q <= 1'b1;
                b_q    <= i_md_op[1] ? '0 : rs1_v;
              end
            end else begin
              m_q <= mag1;
              b_q <= mag2;
            end
          end else begin
            result_q <= alu_res;
            valid_q  <= 1'b1;
          end
        end else if (state_q == S_MUL) begin
          a_q   <= mul_a_nxt;
          b_q   <= mul_b_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            result_q <= mul_res;
            valid_q  <= 1'b1;
          end
        end else if (state_q == S_DIV) begin
          if (spec_q) begin
            result_q <= b_q;
            valid_q  <= 1'b1;
          end else begin
            a_q   <= r;
            b_q   <= q;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              result_q <= div_res;
              valid_q  <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_rd        = rd_q;
  assign o_reg_write = rw_q & valid_q;

endmodule
